// File: rtl/process_engine.sv
// Single-process instruction executor: loadable program memory, NREGS x WIDTH
// register file, one instruction per clock, halt/end-of-program/step-limit exit.
module process_engine #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 16,
    parameter int DEPTH     = 32,
    parameter int MAX_STEPS = 100,
    localparam int RW = $clog2(NREGS),
    localparam int PW = $clog2(DEPTH + 1),
    localparam int IW = 4 + 3 * RW + WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [PW-1:0]    load_addr,
    input  logic [IW-1:0]    load_data,
    input  logic [PW-1:0]    prog_len,
    input  logic             start,
    input  logic             abort,
    output logic             running,
    output logic             stop,
    output logic             timeout,
    output logic [PW-1:0]    pc,
    output logic [31:0]      steps,
    output logic [WIDTH-1:0] return_code,
    input  logic [RW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [31:0]   MAX_P   = 32'(MAX_STEPS);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SET  = 4'd1;
    localparam logic [3:0] OP_GE   = 4'd2;
    localparam logic [3:0] OP_GT   = 4'd3;
    localparam logic [3:0] OP_LE   = 4'd4;
    localparam logic [3:0] OP_LT   = 4'd5;
    localparam logic [3:0] OP_NE   = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_JNZ  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd12;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    mem  [DEPTH];
    logic [WIDTH-1:0] regs [NREGS];
    logic [PW-1:0]    len;

    logic [IW-1:0]    instr;
    logic [3:0]       op;
    logic [RW-1:0]    dst, src1, src2;
    logic [WIDTH-1:0] imm, s1, s2, result;
    logic             wr_en;
    logic [PW-1:0]    target;

    assign instr = (pc < DEPTH_P) ? mem[pc[AW-1:0]] : '0;
    assign {op, dst, src1, src2, imm} = instr;
    assign s1       = regs[src1];
    assign s2       = regs[src2];
    assign target   = PW'(imm);
    assign dbg_data = regs[dbg_addr];

    always_comb begin
        result = '0;
        wr_en  = 1'b1;
        case (op)
            OP_SET:  result = imm;
            OP_GE:   result = WIDTH'(s1 >= s2);
            OP_GT:   result = WIDTH'(s1 >  s2);
            OP_LE:   result = WIDTH'(s1 <= s2);
            OP_LT:   result = WIDTH'(s1 <  s2);
            OP_NE:   result = WIDTH'(s1 != s2);
            OP_EQ:   result = WIDTH'(s1 == s2);
            OP_ADD:  result = s1 + s2;
            OP_SUB:  result = s1 - s2;
            default: wr_en  = 1'b0;
        endcase
    end

    // Program memory is deliberately outside reset so a loaded program survives it.
    always_ff @(posedge clock) begin
        if (load_en && state != RUN && load_addr < DEPTH_P)
            mem[load_addr[AW-1:0]] <= load_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            steps       <= '0;
            return_code <= '0;
            timeout     <= 1'b0;
            running     <= 1'b0;
            stop        <= 1'b0;
            len         <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        running     <= 1'b1;
                        stop        <= 1'b0;
                        pc          <= '0;
                        steps       <= '0;
                        timeout     <= 1'b0;
                        return_code <= '0;
                        len         <= (prog_len > DEPTH_P) ? DEPTH_P : prog_len;
                        for (int i = 0; i < NREGS; i++)
                            regs[i] <= '0;
                    end
                end
                RUN: begin
                    if (abort || steps == MAX_P || pc >= len) begin
                        state   <= DONE;
                        running <= 1'b0;
                        stop    <= 1'b1;
                        if (abort)
                            return_code <= '1;
                        else if (steps == MAX_P)
                            timeout <= 1'b1;
                        else
                            return_code <= '0;
                    end else begin
                        case (op)
                            OP_JMP: begin
                                pc    <= target;
                                steps <= steps + 32'd1;
                            end
                            OP_JNZ: begin
                                pc    <= (s1 != '0) ? target : pc + PW'(1);
                                steps <= steps + 32'd1;
                            end
                            OP_HALT: begin
                                return_code <= imm;
                                steps       <= steps + 32'd1;
                                state       <= DONE;
                                running     <= 1'b0;
                                stop        <= 1'b1;
                            end
                            4'd13, 4'd14, 4'd15: begin
                                // Illegal opcode: terminate without counting a step.
                                return_code <= '1;
                                state       <= DONE;
                                running     <= 1'b0;
                                stop        <= 1'b1;
                            end
                            default: begin
                                if (wr_en)
                                    regs[dst] <= result;
                                pc    <= pc + PW'(1);
                                steps <= steps + 32'd1;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/process_engine.md
Name: process_engine

Overview:
- Parametrised single-process instruction executor: a hardware successor to the fixed, straight-line chip process used to check the Java model.
- Holds a loadable program memory and a register file of NREGS x WIDTH registers.
- Executes one instruction per clock: set, six comparisons, add/sub, jumps, halt.
- Terminates on halt, on running off the end of the program, or on a step limit. Exposes pc, step count, return code and a debug register read port to the chip trace logic.

Parameters:
- WIDTH, 8: data register width in bits.
- NREGS, 16: number of registers; RW = clog2(NREGS).
- DEPTH, 32: program memory entries; PW = clog2(DEPTH+1).
- MAX_STEPS, 100: maximum instructions executed per run before timeout.
- Instruction word IW = 4 + 3*RW + WIDTH, packed as {op[3:0], dst, src1, src2, imm}.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- load_en  in  1  program write strobe.
- load_addr  in  PW  program write address.
- load_data  in  IW  instruction word.
- prog_len  in  PW  program length, sampled on start.
- start  in  1  begin a run (accepted in IDLE or DONE).
- abort  in  1  force termination while running.
- running  out  1  high while in RUN.
- stop  out  1  high in DONE.
- timeout  out  1  last run ended by the step limit.
- pc  out  PW  program counter.
- steps  out  32  instructions executed this run.
- return_code  out  WIDTH  termination code.
- dbg_addr  in  RW  debug register select.
- dbg_data  out  WIDTH  combinational read of reg[dbg_addr].

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - pc, steps, return_code, all registers, timeout, running and stop all go to 0.
  - Program memory is not cleared.
  - Reset mid-run abandons the run immediately.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE on halt, end of program, timeout or abort.
  - DONE -> RUN on start.
- Loading:
  - load_en writes load_data to mem[load_addr] at the edge, in IDLE or DONE only.
  - Ignored in RUN.
  - load_addr >= DEPTH is ignored.
- Start edge:
  - pc <= 0, steps <= 0, timeout <= 0, return_code <= 0.
  - All registers <= 0.
  - Latch prog_len, clamped to DEPTH.
  - No instruction executes on this edge.
- Each RUN edge, first matching rule wins:
  - abort -> DONE, return_code = all ones.
  - steps == MAX_STEPS -> DONE, timeout = 1.
  - pc >= len -> DONE, return_code = 0.
  - Otherwise execute mem[pc], then steps += 1 and pc += 1 unless the instruction is a taken jump.
- Opcodes (results visible the cycle after execute; comparisons unsigned, write 1 or 0 zero-extended):
  - 0 NOP.
  - 1 SET: dst = imm.
  - 2 GE: dst = s1 >= s2.
  - 3 GT: dst = s1 > s2.
  - 4 LE: dst = s1 <= s2.
  - 5 LT: dst = s1 < s2.
  - 6 NE: dst = s1 != s2.
  - 7 EQ: dst = s1 == s2.
  - 8 ADD: dst = s1 + s2, mod 2^WIDTH.
  - 9 SUB: dst = s1 - s2, mod 2^WIDTH (wraps).
  - 10 JMP: pc = imm[PW-1:0].
  - 11 JNZ: if s1 != 0 then pc = imm, else pc += 1.
  - 12 HALT: return_code = imm -> DONE. Counts as a step; pc is not incremented.
  - 13-15 illegal: return_code = all ones -> DONE, not counted.
- Operand rules:
  - dst == src is legal; the source is read before the write.
  - A jump target >= len terminates with rc 0 on the next edge.
- DONE state:
  - Registers, pc, steps and return_code hold.
  - dbg_data remains readable.
  - start and load_en in the same cycle: the load applies and the run starts; the new instruction is visible at execute.

Test Plan:
- Comparison program:
  - Stimulus: SET r0=0, SET r1=1, SET r2=2, SET r3=3, then GE r4=(r0,r1), GT r5=(r0,r1), LE r6=(r1,r0), LT r7=(r1,r0), NE r8=(r0,r0), EQ r9=(r0,r1), GE r10=(r1,r0), GT r11=(r1,r0), LE r12=(r0,r1), LT r13=(r0,r1), NE r14=(r0,r1), EQ r15=(r1,r1); len=16.
  - Required: r4..r9 = 0; r10..r15 = 1; stop after 16 execute edges; pc=16; steps=16; rc=0; timeout=0.
- Loop and halt:
  - Stimulus: SET r0=5, SET r1=1, SUB r0=r0-r1, JNZ r0->2, HALT imm=0x2A.
  - Required: r0=0, rc=42, steps=13, pc=4.
- Timeout:
  - Stimulus: JMP 0 only, MAX_STEPS=100.
  - Required: stop with timeout=1, steps=100, rc=0.
- Wrap-around:
  - Stimulus: SUB of 0-1, then ADD of 255+2 (WIDTH=8).
  - Required: 255 and 1.
- Abort and illegal opcode:
  - Stimulus: abort at step 3 of the loop program.
  - Required: DONE, rc=255, steps=3.
  - Stimulus: opcode 14 at pc 0.
  - Required: rc=255, steps=0.
- Reset and load guard:
  - Stimulus: load_en during RUN.
  - Required: memory unchanged.
  - Stimulus: reset_n low mid-run.
  - Required: all outputs 0 within the same cycle, independent of clock; a subsequent start reruns the program correctly.
